// File: rtl/seq_signed_multiplier.sv
// Multi-cycle signed shift-add multiplier with valid/ready handshakes.
// Optional build macro: SEQ_MULT_UNSIGNED_MODE_EN (adds signed_mode input).
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    operand handshake (ready only in IDLE)
//   a, b                 WIDTH-bit operands (two's complement)
//   out_valid/out_ready  result handshake
//   result               2*WIDTH-bit product, held while out_valid=1
//   busy                 high outside IDLE
//   signed_mode          (macro only) 1=signed, 0=unsigned operands
module seq_signed_multiplier #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef SEQ_MULT_UNSIGNED_MODE_EN
  input  logic               signed_mode,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE,
    ABS,
    RUN,
    FIX,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [2*WIDTH-1:0] ONE =
    {{(2*WIDTH-1){1'b0}}, 1'b1};

  state_t               state;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic                 neg_q;
  logic [2*WIDTH-1:0]   acc;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   addend;

`ifdef SEQ_MULT_UNSIGNED_MODE_EN
  logic                 sm_q;
`endif

  // Magnitude is unsigned, so -2^(WIDTH-1) maps cleanly to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(
    input logic [WIDTH-1:0] x
  );
    mag = x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
  endfunction

  assign addend = {{WIDTH{1'b0}}, mcand} << cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      neg_q     <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      result    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef SEQ_MULT_UNSIGNED_MODE_EN
      sm_q      <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= a;
            mplier   <= b;
`ifdef SEQ_MULT_UNSIGNED_MODE_EN
            sm_q     <= signed_mode;
            neg_q    <= signed_mode
                      & (a[WIDTH-1] ^ b[WIDTH-1]);
`else
            neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ABS;
          end
        end
        ABS: begin
`ifdef SEQ_MULT_UNSIGNED_MODE_EN
          if (sm_q) begin
            mcand  <= mag(mcand);
            mplier <= mag(mplier);
          end
`else
          mcand  <= mag(mcand);
          mplier <= mag(mplier);
`endif
          acc   <= '0;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          if (mplier[0]) begin
            acc <= acc + addend;
          end
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          // Carry-out of the negation is dropped, so zero stays zero.
          result    <= neg_q ? (~acc + ONE) : acc;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
